// File: rtl/sound_pkg.sv
// sound_pkg: shared types and constants for the sound path
// (logo event logic, sound_scheduler, sound_controller).
package sound_pkg;

  localparam int CODE_W = 2;
  localparam int DUR_W  = 8;

  // Sound codes understood by sound_controller.
  localparam logic [CODE_W-1:0] SND_NONE   = 2'b00;
  localparam logic [CODE_W-1:0] SND_BOUNCE = 2'b01;
  localparam logic [CODE_W-1:0] SND_SPEED  = 2'b10;
  localparam logic [CODE_W-1:0] SND_ALERT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // A duration of zero ticks plays for one tick.
  function automatic logic [DUR_W-1:0] dur_eff(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

endpackage

// File: rtl/sound_arbiter.sv
// sound_arbiter: combinational one-hot pick among pending sound requests.
// Build option ROUND_ROBIN_EN: search upward from ptr with wrap-around;
// otherwise fixed priority, lowest index wins.
module sound_arbiter
  import sound_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] pending,
`ifdef ROUND_ROBIN_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic             any,
  output logic [IDX_W-1:0] win_idx,
  output logic [N_REQ-1:0] win_oh
);

`ifdef ROUND_ROBIN_EN
  // Round-robin: first pending source at or above ptr, wrapping to 0.
  always_comb begin
    logic found;
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path can leave a value held (latch).
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && pending[j]) begin
        found   = 1'b1;
        win_idx = IDX_W'(j);
      end
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest pending index.
  always_comb begin
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending[i]) win_idx = IDX_W'(i);
    end
  end
`endif

  assign any    = |pending;
  assign win_oh = any ? (N_REQ'(1) << win_idx) : '0;

endmodule

// File: rtl/sound_scheduler.sv
// sound_scheduler: time-shares the single sound channel among N_REQ event
// sources. One pending request per source (latest wins), arbitration in
// IDLE, exact-length PLAY measured in ticks of TICK_DIV cycles, then a
// silent GAP of GAP_CYC cycles. Build option ROUND_ROBIN_EN selects
// round-robin arbitration instead of fixed priority.
module sound_scheduler
  import sound_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int TICK_DIV = 12000,
  parameter int GAP_CYC  = 1200
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [N_REQ-1:0]        req,
  input  logic [CODE_W*N_REQ-1:0] req_code,
  input  logic [DUR_W*N_REQ-1:0]  req_dur,
  output logic [N_REQ-1:0]        grant,
  output logic [CODE_W-1:0]       code_sound,
  output logic                    mute,
  output logic                    busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYC - 1);

  state_t            state;
  logic [N_REQ-1:0]  pending;
  logic [CODE_W-1:0] code_q [N_REQ];
  logic [DUR_W-1:0]  dur_q  [N_REQ];
  logic [DUR_W-1:0]  play_dur;
  logic [DUR_W-1:0]  tick_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic              any;
  logic [IDX_W-1:0]  win_idx;
  logic [N_REQ-1:0]  win_oh;
  logic [N_REQ-1:0]  take_oh;

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0]  ptr;
`endif

  sound_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arbiter (
    .pending (pending),
`ifdef ROUND_ROBIN_EN
    .ptr     (ptr),
`endif
    .any     (any),
    .win_idx (win_idx),
    .win_oh  (win_oh)
  );

  // A grant only happens from IDLE; this is the pending bit it consumes.
  assign take_oh = (state == ST_IDLE) ? win_oh : '0;

  // Per-source code/duration capture; the latest request overwrites.
  // NOTE: this storage has no reset on purpose: it is only read when the
  // matching pending bit is set, and pending itself is reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) begin
        code_q[i] <= req_code[CODE_W*i +: CODE_W];
        dur_q[i]  <= req_dur[DUR_W*i +: DUR_W];
      end
    end
  end

  // Pending set by a request, cleared by its grant; a same-cycle request
  // wins so the source is queued again.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (clr) pending <= '0;
    else     pending <= (pending & ~take_oh) | req;
  end

  // Scheduler FSM with registered grant/code/mute/busy outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= ST_IDLE;
      grant      <= '0;
      code_sound <= SND_NONE;
      mute       <= 1'b1;
      busy       <= 1'b0;
      play_dur   <= DUR_W'(1);
      tick_cnt   <= '0;
      div_cnt    <= '0;
      gap_cnt    <= '0;
`ifdef ROUND_ROBIN_EN
      ptr        <= '0;
`endif
    end else begin
      grant <= '0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            state      <= ST_PLAY;
            grant      <= win_oh;
            code_sound <= code_q[win_idx];
            play_dur   <= dur_eff(dur_q[win_idx]);
            tick_cnt   <= '0;
            div_cnt    <= '0;
            mute       <= 1'b0;
            busy       <= 1'b1;
`ifdef ROUND_ROBIN_EN
            ptr        <= (int'(win_idx) == N_REQ - 1) ? '0 : IDX_W'(win_idx + 1'b1);
`endif
          end
        end
        ST_PLAY: begin
          if (div_cnt == DIV_MAX) begin
            div_cnt <= '0;
            if (tick_cnt == DUR_W'(play_dur - 1'b1)) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
              mute    <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_MAX) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          mute  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sound_scheduler.md
# sound_scheduler

Time-shares the single sound channel (code_sound/mute into sound_controller) among N_REQ event sources such as logo bounce and velocity-change events. Each source pulses a request carrying a sound code and duration. The block queues one pending request per source and arbitrates between them. It plays the granted sound for an exact number of millisecond ticks, then inserts a silent gap before the next grant. It sits between logo-level event logic and sound_controller in top.

## Interface
- N_REQ, 4: number of requesters (2..8).
- TICK_DIV, 12000: clk cycles per duration tick (1 ms at 12 MHz).
- GAP_CYC, 1200: silent cycles after each sound (≥1).
- clk  in  1  system clock, 12 MHz.
- clr  in  1  reset; synchronous, active-high.
- req  in  N_REQ  per-source single-cycle request pulse.
- req_code  in  2*N_REQ  sound code of source i at bits [2i+1:2i].
- req_dur  in  8*N_REQ  duration in ticks of source i at bits [8i+7:8i]; 0 is treated as 1.
- grant  out  N_REQ  one-hot, one-cycle pulse when source i starts playing.
- code_sound  out  2  code to sound_controller.
- mute  out  1  1 = silent.
- busy  out  1  1 in PLAY or GAP.

## Operation
- Per source: pending bit, stored code (2 b), stored duration (8 b).
- req[i] high: pending[i] set, code/duration for source i overwritten (latest wins).
- FSM states:
  - IDLE: any pending → PLAY.
  - PLAY: cycle counter reaches max(dur,1)*TICK_DIV → GAP.
  - GAP: GAP_CYC cycles elapsed → IDLE.
- Arbitration is evaluated only in IDLE; the winner's code and duration are copied into play registers.
- Granting source i clears pending[i]. If req[i] is high in that same cycle, pending[i] stays set and the stored values are updated; the current grant uses the pre-update values.
- No preemption: requests arriving during PLAY/GAP only set pending.
- Duration counter: 8-bit tick count × divider counter of ceil(log2 TICK_DIV) bits. Both counters clear on entry to PLAY, so duration is exact and independent of phase.
- Outputs:
  - PLAY: mute=0, code_sound=play code.
  - GAP and IDLE: mute=1, code_sound holds its last value.
- Reset values: state IDLE, pending=0, grant=0, mute=1, code_sound=0, busy=0, rr pointer=0.
- clr asserted mid-PLAY: all state returns to reset values on the next edge, and pending requests are discarded.

## Timing
- Request pulse at cycle t: pending visible at t+1. If IDLE at t+1, then at t+2 state=PLAY, grant[i]=1, mute=0 and code_sound valid. Latency is 2 cycles.
- grant is high exactly one cycle, aligned with the first PLAY cycle.
- mute stays low for exactly max(dur,1)*TICK_DIV cycles.
- Back-to-back grants: mute high for GAP_CYC+1 cycles (GAP plus one IDLE arbitration cycle).
- All outputs are registered; no combinational path from req to outputs.

## Configuration
- ROUND_ROBIN_EN defined:
  - Round-robin arbitration; pointer = index after the last granted source.
  - Search proceeds upward from the pointer, wrapping at N_REQ-1 → 0.
  - Pointer updates on each grant.
- Undefined: fixed priority, lowest index wins; no pointer register.

## Structure
- Package sound_pkg holds:
  - state enum (IDLE, PLAY, GAP);
  - CODE_W=2 and DUR_W=8;
  - named sound code constants shared with sound_controller and logo.
- Sub-module sound_arbiter: combinational pick of one-hot winner from pending and pointer. It contains the ROUND_ROBIN_EN selection; the FSM, counters and storage stay in sound_scheduler.

## Test plan
Bench parameters: TICK_DIV=4, GAP_CYC=2, N_REQ=4.
- Reset: clr high 3 cycles → mute=1, code_sound=0, grant=0, busy=0; holds with no requests.
- Single request: req[2] pulse with code 2'b10, dur 3 at cycle 10 → grant[2] and mute=0 at cycle 12; code_sound=2'b10 for 12 cycles; mute=1 from cycle 24; busy low at cycle 26.
- Contention: req[1] and req[3] pulsed together, dur 1.
  - Fixed priority: source 1 plays first, then source 3 after a 3-cycle mute gap.
  - ROUND_ROBIN_EN, pointer=2: source 3 plays first.
- Zero and overwrite:
  - req[0] with dur 0 → mute low exactly 4 cycles.
  - Second req[0] with a new code during the first PLAY → the second play uses the new code; only one extra play occurs.
- Same-cycle re-request: req[i] pulses in its own grant cycle → current play uses the old code; source i is granted again after the gap.
- Reset mid-PLAY: clr during PLAY with two pending requests → mute=1 next cycle; no grant follows after release.
